// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and width helper for the systolic feed controller.
package systolic_pkg;

  localparam int N          = 3;
  localparam int FEED_STEPS = 2 * N - 1;
  localparam int STEP_W     = $clog2(FEED_STEPS);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StDrain,
    StOut
  } feed_state_t;

  function automatic int unsigned res_w(int unsigned dw);
    return 2 * dw + 1;
  endfunction

endpackage

// File: rtl/systolic_skew_gen.sv
// Combinational skew generator: selects the diagonal wavefront of A rows and B columns for a step.
module systolic_skew_gen
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [STEP_W-1:0]           step,
  input  logic [N*N*DATA_WIDTH-1:0]   a,
  input  logic [N*N*DATA_WIDTH-1:0]   b,
  output logic [N*DATA_WIDTH-1:0]     op_a,
  output logic [N*DATA_WIDTH-1:0]     op_b
);

  // Row i of A and column i of B are both delayed by i steps, so one window test covers both.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(step) >= i && int'(step) - i < N) begin
        op_a[i*DATA_WIDTH +: DATA_WIDTH] = a[(i*N + int'(step) - i)*DATA_WIDTH +: DATA_WIDTH];
        op_b[i*DATA_WIDTH +: DATA_WIDTH] = b[((int'(step) - i)*N + i)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Job controller for a 3x3 output-stationary systolic array: accept, clear, feed, drain, present.
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [9*DATA_WIDTH-1:0]                in_a,
  input  logic [9*DATA_WIDTH-1:0]                in_b,
  output logic                                   arr_clr,
  output logic [DATA_WIDTH-1:0]                  arr_a1,
  output logic [DATA_WIDTH-1:0]                  arr_a2,
  output logic [DATA_WIDTH-1:0]                  arr_a3,
  output logic [DATA_WIDTH-1:0]                  arr_b1,
  output logic [DATA_WIDTH-1:0]                  arr_b2,
  output logic [DATA_WIDTH-1:0]                  arr_b3,
  input  logic [9*(2*DATA_WIDTH+1)-1:0]          arr_c,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [9*(2*DATA_WIDTH+1)-1:0]          out_c,
  output logic                                   busy
);

  localparam int unsigned ResW   = res_w(DATA_WIDTH);
  localparam int unsigned CntMax = (FEED_STEPS > DRAIN_CYCLES) ? FEED_STEPS : DRAIN_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax);

  feed_state_t state_q, state_d;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic [9*DATA_WIDTH-1:0]      a_q, b_q;
  logic [N*DATA_WIDTH-1:0]      op_a_q, op_b_q, skew_a, skew_b;
  logic                         clr_q;
  logic [9*ResW-1:0]            out_c_q;
  logic                         accept, capture;

  // Fed with the next step so the registered operands line up with the FEED cycle they belong to.
  systolic_skew_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skew_gen (
    .step(cnt_d[STEP_W-1:0]),
    .a   (a_q),
    .b   (b_q),
    .op_a(skew_a),
    .op_b(skew_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) state_d = StClear;
      end
      StClear: begin
        state_d = StFeed;
        cnt_d   = '0;
      end
      StFeed: begin
        if (cnt_q == CntW'(FEED_STEPS - 1)) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDrain: begin
        if (cnt_q == CntW'(DRAIN_CYCLES - 1)) begin
          state_d = StOut;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q != StIdle);
    out_valid = (state_q == StOut);
    accept    = (state_q == StIdle) && in_valid;
    capture   = (state_q == StDrain) && (state_d == StOut);
  end

  // clr_q resets high so the array is held clear for as long as reset is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      clr_q   <= 1'b1;
      out_c_q <= '0;
    end else begin
      clr_q  <= (state_d == StClear);
      op_a_q <= (state_d == StFeed) ? skew_a : '0;
      op_b_q <= (state_d == StFeed) ? skew_b : '0;
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      if (capture) out_c_q <= arr_c;
    end
  end

  assign arr_clr = clr_q;
  assign arr_a1  = op_a_q[0*DATA_WIDTH +: DATA_WIDTH];
  assign arr_a2  = op_a_q[1*DATA_WIDTH +: DATA_WIDTH];
  assign arr_a3  = op_a_q[2*DATA_WIDTH +: DATA_WIDTH];
  assign arr_b1  = op_b_q[0*DATA_WIDTH +: DATA_WIDTH];
  assign arr_b2  = op_b_q[1*DATA_WIDTH +: DATA_WIDTH];
  assign arr_b3  = op_b_q[2*DATA_WIDTH +: DATA_WIDTH];
  assign out_c   = out_c_q;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Scoreboard bench: behavioural 3x3 array model, matrix-product reference, skew/timing monitor.
module tb_systolic_feed_ctrl;

  localparam int DW    = 8;
  localparam int DRAIN = 3;
  localparam int RW    = 2 * DW + 1;

  typedef logic [9*DW-1:0] mat_t;
  typedef logic [9*RW-1:0] res_t;
  typedef struct packed {
    mat_t a;
    mat_t b;
  } job_t;

  localparam mat_t RefA  = {8'd5, 8'd9, 8'd1, 8'd9, 8'd6, 8'd5, 8'd7, 8'd4, 8'd7};
  localparam mat_t RefB  = {8'd7, 8'd5, 8'd8, 8'd5, 8'd9, 8'd7, 8'd3, 8'd5, 8'd2};
  localparam mat_t Ident = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
  localparam mat_t AllFf = {9{8'hff}};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy, arr_clr;
  mat_t in_a = '0, in_b = '0;
  logic [DW-1:0] arr_a1, arr_a2, arr_a3, arr_b1, arr_b2, arr_b3;
  res_t arr_c, out_c;

  always #5 clk = ~clk;

  systolic_feed_ctrl #(
    .DATA_WIDTH  (DW),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .arr_clr  (arr_clr),
    .arr_a1   (arr_a1),
    .arr_a2   (arr_a2),
    .arr_a3   (arr_a3),
    .arr_b1   (arr_b1),
    .arr_b2   (arr_b2),
    .arr_b3   (arr_b3),
    .arr_c    (arr_c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_c    (out_c),
    .busy     (busy)
  );

  // Output-stationary array: a moves right, b moves down, each cell accumulates (wraps at RW bits).
  logic [DW-1:0] pa[3][3], pb[3][3], ain[3], bin[3];
  logic [RW-1:0] acc[3][3];
  assign ain[0] = arr_a1;
  assign ain[1] = arr_a2;
  assign ain[2] = arr_a3;
  assign bin[0] = arr_b1;
  assign bin[1] = arr_b2;
  assign bin[2] = arr_b3;

  always @(posedge clk or posedge arr_clr) begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (arr_clr) begin
          pa[r][c]  <= '0;
          pb[r][c]  <= '0;
          acc[r][c] <= '0;
        end else begin
          logic [DW-1:0] av, bv;
          av = (c == 0) ? ain[r] : pa[r][(c == 0) ? 0 : c-1];
          bv = (r == 0) ? bin[c] : pb[(r == 0) ? 0 : r-1][c];
          pa[r][c]  <= av;
          pb[r][c]  <= bv;
          acc[r][c] <= acc[r][c] + RW'(av) * RW'(bv);
        end
      end
    end
  end

  always_comb begin
    arr_c = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) arr_c[(r*3+c)*RW +: RW] = acc[r][c];
  end

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  job_t job_q[$];

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] el(mat_t m, int r, int c);
    return m[(r*3+c)*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] sk_a(mat_t m, int k, int r);
    return (k - r >= 0 && k - r <= 2) ? el(m, r, k - r) : '0;
  endfunction

  function automatic logic [DW-1:0] sk_b(mat_t m, int k, int c);
    return (k - c >= 0 && k - c <= 2) ? el(m, k - c, c) : '0;
  endfunction

  // 3*255*255 does not fit in RW bits; the array's wrapped sum is what passes through unchanged.
  function automatic res_t matmul(mat_t a, mat_t b);
    res_t res = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        int unsigned s = 0;
        for (int k = 0; k < 3; k++) s += el(a, r, k) * el(b, k, c);
        res[(r*3+c)*RW +: RW] = RW'(s);
      end
    return res;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < 9; i++) m[i*DW +: DW] = DW'($urandom_range(0, 255));
    return m;
  endfunction

  // Monitor: ph counts cycles since the accept cycle (0); -1 when no job is in flight.
  int   ph = -1;
  bit   seen = 1'b0;
  job_t cur;

  always @(negedge clk) begin
    if (!rst) begin
      ph   = -1;
      seen = 1'b0;
    end else begin
      if (ph >= 0) ph++;
      if (in_valid && in_ready) begin
        if (job_q.size() == 0) chk("unexpected_accept", 1, 0);
        else begin
          cur  = job_q.pop_front();
          ph   = 0;
          seen = 1'b0;
        end
      end
      if (ph == 1) chk("clr_pulse", arr_clr, 1);
      if (ph == 2) chk("clr_drop", arr_clr, 0);
      if (ph >= 2 && ph <= 6) begin
        chk("skew_a", {arr_a1, arr_a2, arr_a3},
            {sk_a(cur.a, ph-2, 0), sk_a(cur.a, ph-2, 1), sk_a(cur.a, ph-2, 2)});
        chk("skew_b", {arr_b1, arr_b2, arr_b3},
            {sk_b(cur.b, ph-2, 0), sk_b(cur.b, ph-2, 1), sk_b(cur.b, ph-2, 2)});
      end
      if (ph == 7) chk("ops_zero", {arr_a1, arr_a2, arr_a3, arr_b1, arr_b2, arr_b3}, 0);
      if (ph >= 1 && ph < 7 + DRAIN) chk("busy_flags", {in_ready, busy, out_valid}, 3'b010);
      if (out_valid) begin
        if (ph < 0) chk("spurious_valid", 1, 0);
        else begin
          if (!seen) chk("latency", ph, 7 + DRAIN);
          else chk("hold_ready", in_ready, 0);
          chk(seen ? "hold_c" : "out_c", out_c, matmul(cur.a, cur.b));
          seen = 1'b1;
          if (out_ready) begin
            ph = -1;
            done_cnt++;
          end
        end
      end
    end
  end

  task automatic send(mat_t a, mat_t b, bit hold_iv);
    int n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    job_q.push_back(job_t'({a, b}));
    @(posedge clk); #1;
    if (!hold_iv) in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("valid_seen", out_valid, 1);
  endtask

  task automatic wait_done(int target);
    int n = 0;
    while (done_cnt < target && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("jobs_done", done_cnt >= target, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int base;
    #12;
    chk("reset_flags", {in_ready, busy, arr_clr, out_valid}, 4'b1010);
    chk("reset_data", {out_c, arr_a1, arr_a2, arr_a3, arr_b1, arr_b2, arr_b3}, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("clr_idle", {arr_clr, in_ready}, 2'b01);

    // Reference job
    base = done_cnt;
    send(RefA, RefB, 1'b0);
    wait_done(base + 1);

    // Backpressure for 20 cycles
    out_ready = 1'b0;
    base = done_cnt;
    send(RefA, RefB, 1'b0);
    wait_valid();
    repeat (20) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(base + 1);

    // Back-to-back: reference then identity * B
    base = done_cnt;
    send(RefA, RefB, 1'b0);
    send(Ident, RefB, 1'b0);
    wait_done(base + 2);

    // All-max operands
    base = done_cnt;
    send(AllFf, AllFf, 1'b0);
    wait_done(base + 1);

    // in_valid held high and inputs scrambled during the job
    base = done_cnt;
    send(RefA, RefB, 1'b1);
    for (int n = 0; n < 50 && !out_valid; n++) begin
      in_a = rand_mat();
      in_b = rand_mat();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_done(base + 1);

    // Reset during FEED step 2 (cycle 4 after accept)
    send(RefA, RefB, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_flags", {in_ready, busy, arr_clr, out_valid}, 4'b1010);
    chk("midrst_data", {out_c, arr_a1, arr_a2, arr_a3, arr_b1, arr_b2, arr_b3}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    base = done_cnt;
    send(RefA, RefB, 1'b0);
    wait_done(base + 1);

    // Randomised jobs with random output stalls
    for (int j = 0; j < 6; j++) begin
      mat_t ra, rb;
      ra = rand_mat();
      rb = rand_mat();
      out_ready = 1'($urandom_range(0, 1));
      base = done_cnt;
      send(ra, rb, 1'b0);
      if (!out_ready) begin
        wait_valid();
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      wait_done(base + 1);
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
